// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register map and encoding constants for apb_gpio_irq
package gpio_pkg;

  localparam int unsigned REG_DIR     = 0;
  localparam int unsigned REG_OUT     = 1;
  localparam int unsigned REG_IN      = 2;
  localparam int unsigned REG_IE      = 3;
  localparam int unsigned REG_ITYPE   = 4;
  localparam int unsigned REG_IPOL    = 5;
  localparam int unsigned REG_ISTAT   = 6;
  localparam int unsigned REG_OUT_SET = 7;
  localparam int unsigned REG_OUT_CLR = 8;
  localparam int unsigned REG_OUT_TGL = 9;

  // Highest mapped index for each build flavour; anything above raises PSLVERR.
  localparam int unsigned REG_LAST_BASE   = REG_ISTAT;
  localparam int unsigned REG_LAST_ATOMIC = REG_OUT_TGL;

  localparam logic ITYPE_EDGE  = 1'b1;
  localparam logic ITYPE_LEVEL = 1'b0;
  localparam logic IPOL_HIGH   = 1'b1;
  localparam logic IPOL_LOW    = 1'b0;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - STAGES x WIDTH flop chain bringing asynchronous pad inputs into PCLK
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - APB3 GPIO slave with per-pin edge/level interrupts
// Define GPIO_ATOMIC_OUT_EN to add the OUT_SET/OUT_CLR/OUT_TGL registers at indexes 7-9.
module apb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [WIDTH-1:0]  PWDATA,
  output logic [WIDTH-1:0]  PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

`ifdef GPIO_ATOMIC_OUT_EN
  localparam int unsigned REG_LIMIT = REG_LAST_ATOMIC;
`else
  localparam int unsigned REG_LIMIT = REG_LAST_BASE;
`endif

  logic [WIDTH-1:0] dir_q, out_q, ie_q, itype_q, ipol_q, istat_q, prev_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rdata_sel;
  logic [31:0]      addr_ext;
  logic             access, mapped, wr_en;

  gpio_sync #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(PCLK),
    .rst(PRESET),
    .d  (gpio_i),
    .q  (sync)
  );

  assign addr_ext = 32'(PADDR);
  assign access   = PSEL & PENABLE;
  assign mapped   = (addr_ext <= REG_LIMIT);
  assign wr_en    = access & PWRITE & mapped;
  assign PREADY   = 1'b1;
  assign PSLVERR  = access & ~mapped;

  always_comb begin
    rdata_sel = '0;
    case (addr_ext)
      REG_DIR:   rdata_sel = dir_q;
      REG_OUT:   rdata_sel = out_q;
      REG_IN:    rdata_sel = sync;
      REG_IE:    rdata_sel = ie_q;
      REG_ITYPE: rdata_sel = itype_q;
      REG_IPOL:  rdata_sel = ipol_q;
      REG_ISTAT: rdata_sel = istat_q;
      default:   rdata_sel = '0;
    endcase
  end

  assign PRDATA = (access && !PWRITE && mapped) ? rdata_sel : '0;

  // Interrupt event detection; masks are normalised so 1 = edge mode / rising-high.
  logic [WIDTH-1:0] edge_mask, rise_sel, rise, fall, edge_evt, level_evt;
  logic [WIDTH-1:0] w1c, to_edge, istat_next;

  assign edge_mask = itype_q ^ {WIDTH{~ITYPE_EDGE}};
  assign rise_sel  = ipol_q ^ {WIDTH{~IPOL_HIGH}};
  assign rise      = sync & ~prev_q;
  assign fall      = ~sync & prev_q;
  assign edge_evt  = (rise_sel & rise) | (~rise_sel & fall);
  assign level_evt = ~(sync ^ rise_sel);

  assign w1c     = (wr_en && addr_ext == REG_ISTAT) ? PWDATA : '0;
  assign to_edge = (wr_en && addr_ext == REG_ITYPE)
                 ? ((PWDATA ^ {WIDTH{~ITYPE_EDGE}}) & ~edge_mask) : '0;

  // A new edge beats a same-cycle W1C; a level->edge switch starts from a clean bit.
  assign istat_next = ~to_edge & ((edge_mask & (edge_evt | (istat_q & ~w1c)))
                                | (~edge_mask & level_evt));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      dir_q   <= '0;
      out_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      istat_q <= '0;
      prev_q  <= '0;
      irq     <= 1'b0;
    end else begin
      prev_q  <= sync;
      istat_q <= istat_next;
      irq     <= |(istat_q & ie_q);
      if (wr_en) begin
        case (addr_ext)
          REG_DIR:     dir_q   <= PWDATA;
          REG_OUT:     out_q   <= PWDATA;
          REG_IE:      ie_q    <= PWDATA;
          REG_ITYPE:   itype_q <= PWDATA;
          REG_IPOL:    ipol_q  <= PWDATA;
`ifdef GPIO_ATOMIC_OUT_EN
          REG_OUT_SET: out_q   <= out_q | PWDATA;
          REG_OUT_CLR: out_q   <= out_q & ~PWDATA;
          REG_OUT_TGL: out_q   <= out_q ^ PWDATA;
`endif
          default: ;
        endcase
      end
    end
  end

  assign gpio_oe = dir_q;
  assign gpio_o  = out_q;

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised APB3 GPIO slave; next generation of the team's 8-bit GPIO peripheral.
- Adds configurable pin count, an input synchroniser, per-pin interrupts (edge or level, selectable polarity), a sticky write-1-to-clear status register, and PSLVERR for unmapped addresses.
- Sits directly on the APB bus behind the APB master FSM; drives pad output/enable and one interrupt line to the system.

Parameters:
- WIDTH, 8, number of GPIO pins and APB data width (1..32).
- ADDR_W, 4, PADDR width; word-indexed register select.
- SYNC_STAGES, 2, input synchroniser depth (minimum 2).

Ports:
- PCLK  in  1  APB clock; all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  register index.
- PWDATA  in  WIDTH  write data.
- PRDATA  out  WIDTH  read data.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  error on unmapped index.
- gpio_i  in  WIDTH  asynchronous pad inputs.
- gpio_o  out  WIDTH  pad output values.
- gpio_oe  out  WIDTH  pad output enables; 1 = drive.
- irq  out  1  registered interrupt request.

Behaviour:
- Register map by index:
  - 0 DIR rw; drives gpio_oe.
  - 1 OUT rw; drives gpio_o.
  - 2 IN ro; synchronised pin value.
  - 3 IE rw.
  - 4 ITYPE rw; 1 = edge, 0 = level.
  - 5 IPOL rw; 1 = rising/high, 0 = falling/low.
  - 6 ISTAT; W1C for edge bits.
- Reset (async, any time, including mid-transfer): all registers, synchroniser flops, edge-history flop and irq go to 0. PRDATA=0, PSLVERR=0.
- APB handshake:
  - Writes commit on the PCLK edge where PSEL & PENABLE & PWRITE.
  - Reads: PRDATA is combinational from the selected register while PSEL & PENABLE & !PWRITE, and 0 otherwise.
  - PREADY is always 1, so every access completes in two cycles (SETUP, ACCESS).
- Writes to IN are ignored and return PSLVERR=0.
- PSLVERR=1 only in the access phase, for indexes > 6 (or > 9 with the optional feature). An erroring write changes no state; an erroring read returns 0.
- Input path:
  - gpio_i passes through SYNC_STAGES flops to form sync.
  - IN = sync, so a pin change is readable SYNC_STAGES cycles later.
  - prev = sync delayed by one cycle.
- Event, per bit n:
  - Edge mode: rise = sync & ~prev, fall = ~sync & prev; the event is rise when IPOL=1, fall when IPOL=0.
  - Level mode: the event is (sync == IPOL).
- ISTAT[n]:
  - Edge mode: set on an event (sticky); cleared by writing 1 to ISTAT[n].
  - Simultaneous event and W1C in the same cycle: the event wins and the bit stays 1.
  - Level mode: ISTAT[n] tracks the level event every cycle; W1C has no effect.
  - ISTAT latches regardless of IE.
  - Switching ITYPE from level to edge clears ISTAT[n] in that cycle.
- irq is registered: irq <= |(ISTAT & IE). It is 1 cycle after ISTAT updates and SYNC_STAGES+2 cycles after a pin edge.
- Pin read while DIR=1: IN returns the synchronised pad value, which normally echoes OUT.
- A pin that is high at reset release reports a rising edge SYNC_STAGES+1 cycles later (prev resets to 0). This is intended; software clears it after init.

Optional Feature:
- Macro: GPIO_ATOMIC_OUT_EN.
- When defined, adds three write-only registers (read 0):
  - 7 OUT_SET: OUT |= PWDATA.
  - 8 OUT_CLR: OUT &= ~PWDATA.
  - 9 OUT_TGL: OUT ^= PWDATA.
- When not defined, indexes 7-9 are unmapped and raise PSLVERR.

Decomposition:
- Shared package gpio_pkg holds:
  - register index localparams (REG_DIR .. REG_OUT_TGL);
  - the unmapped-index limit constant;
  - the ITYPE/IPOL encoding constants.
- One natural sub-module, gpio_sync: a SYNC_STAGES x WIDTH flop chain with async active-high reset, instantiated once for gpio_i.

Test Plan:
- Reset mid-transfer: assert PRESET during the ACCESS phase of a write of 8'hFF to DIR -> DIR, gpio_oe, irq all 0 immediately; DIR reads 8'h00 afterward.
- Write DIR=8'h03, then OUT=8'h02 -> gpio_oe=8'h03, gpio_o=8'h02; reads return 8'h03 / 8'h02; PSLVERR=0.
- gpio_i=8'h19 -> IN reads 8'h19 from SYNC_STAGES cycles later. Write to IN -> value unchanged, PSLVERR=0.
- Rising-edge interrupt: IE=8'h01, ITYPE=8'h01, IPOL=8'h01; gpio_i[0] goes 0->1 -> ISTAT=8'h01 at SYNC_STAGES+1 cycles and irq=1 one cycle later. Write ISTAT=8'h01 -> ISTAT=0, irq drops next cycle. W1C in the same cycle as a new edge -> ISTAT stays 1.
- Level-low interrupt on pin 3 (ITYPE=0, IPOL=0, IE=8'h08): drive gpio_i[3]=0 -> irq=1. W1C is ignored; irq clears only after gpio_i[3]=1 propagates.
- Access to index 12 -> PSLVERR=1 and PRDATA=0, no state change. With GPIO_ATOMIC_OUT_EN: OUT=8'hF0, then SET 8'h0F, CLR 8'h81, TGL 8'hFF -> OUT=8'h81.
